// File: rtl/msix_pkg.sv
// Shared encodings and types for the MSI-X vector engine.
package msix_pkg;

    // Table field selectors on the config port
    localparam logic [1:0] FLD_ADDR_LO = 2'd0;
    localparam logic [1:0] FLD_ADDR_HI = 2'd1;
    localparam logic [1:0] FLD_DATA    = 2'd2;
    localparam logic [1:0] FLD_CTRL    = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // One vector table entry. addr_hi keeps the full 32-bit slot; bits above
    // ADDR_W-32 are never written so they stay 0 and read back as 0.
    typedef struct packed {
        logic [31:0] addr_lo;
        logic [31:0] addr_hi;
        logic [31:0] data;
        logic        mask;
    } vec_entry_t;

endpackage

// File: rtl/msix_rr_arb.sv
// Round-robin find-first: first set request at or above ptr, wrapping at NUM_VEC.
module msix_rr_arb #(
    parameter int NUM_VEC = 8,
    parameter int IDX_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic [NUM_VEC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    // ptr + off modulo NUM_VEC; ptr is always < NUM_VEC
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= NUM_VEC) s = s - NUM_VEC;
        return IDX_W'(s);
    endfunction

    // Scan from the farthest offset down so the nearest request wins last
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_VEC - 1; i >= 0; i--) begin
            if (req[wrap_add(ptr, i)]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_add(ptr, i);
            end
        end
    end

endmodule

// File: rtl/msix_vec_engine.sv
// MSI-X interrupt generator: vector table, PBA, round-robin issue of DW writes.
module msix_vec_engine
    import msix_pkg::*;
#(
    parameter int NUM_VEC = 8,
    parameter int ADDR_W  = 64,
    parameter int IDX_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_VEC-1:0] intr_req,
    input  logic               msix_en,
    input  logic               func_mask,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [1:0]         cfg_field,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic [NUM_VEC-1:0] pba,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [31:0]        wr_data,
    output logic [IDX_W-1:0]   wr_vec,
    output logic               sent
);

    // Storable bits of addr_hi for this address width
    localparam logic [31:0] HI_MASK = (ADDR_W >= 64) ? 32'hFFFF_FFFF :
                                      32'((64'd1 << (ADDR_W - 32)) - 64'd1);

    vec_entry_t          tbl_q [NUM_VEC];
    logic [NUM_VEC-1:0]  pba_q, pba_d;
    logic [NUM_VEC-1:0]  mask_vec, eligible, clr_vec;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic [IDX_W-1:0]    wr_vec_q, wr_vec_d;
    logic                accept;
    logic                idx_in_range;
    logic                grant_valid;
    logic [IDX_W-1:0]    grant_idx;

    assign idx_in_range = int'(cfg_idx) < NUM_VEC;

    // Vector table: software writes by field; out-of-range index is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VEC; i++) begin
                tbl_q[i] <= '{addr_lo: '0, addr_hi: '0, data: '0, mask: 1'b1};
            end
        end else if (cfg_we && idx_in_range) begin
            case (cfg_field)
                FLD_ADDR_LO: tbl_q[cfg_idx].addr_lo <= cfg_wdata;
                FLD_ADDR_HI: tbl_q[cfg_idx].addr_hi <= cfg_wdata & HI_MASK;
                FLD_DATA:    tbl_q[cfg_idx].data    <= cfg_wdata;
                default:     tbl_q[cfg_idx].mask    <= cfg_wdata[0];
            endcase
        end
    end

    // Combinational readback of the selected field
    always_comb begin
        cfg_rdata = '0;
        if (idx_in_range) begin
            case (cfg_field)
                FLD_ADDR_LO: cfg_rdata = tbl_q[cfg_idx].addr_lo;
                FLD_ADDR_HI: cfg_rdata = tbl_q[cfg_idx].addr_hi;
                FLD_DATA:    cfg_rdata = tbl_q[cfg_idx].data;
                default:     cfg_rdata = {31'd0, tbl_q[cfg_idx].mask};
            endcase
        end
    end

    // Eligibility: pending, unmasked, and function enabled and not masked
    always_comb begin
        for (int i = 0; i < NUM_VEC; i++) mask_vec[i] = tbl_q[i].mask;
        eligible = pba_q & ~mask_vec & {NUM_VEC{msix_en & ~func_mask}};
    end

    msix_rr_arb #(
        .NUM_VEC (NUM_VEC),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req         (eligible),
        .ptr         (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Next-state: grant latches table values, accept clears pending and advances ptr
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_vec_d  = wr_vec_q;
        rr_ptr_d  = rr_ptr_q;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d   = ISSUE;
                    wr_addr_d = {tbl_q[grant_idx].addr_hi[ADDR_W-33:0],
                                 tbl_q[grant_idx].addr_lo[31:2], 2'b00};
                    wr_data_d = tbl_q[grant_idx].data;
                    wr_vec_d  = grant_idx;
                end
            end
            ISSUE: begin
                if (wr_ready) begin
                    accept   = 1'b1;
                    state_d  = IDLE;
                    rr_ptr_d = (int'(wr_vec_q) == NUM_VEC - 1) ? '0 : wr_vec_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // A new request in the accept cycle re-sets the bit (set beats clear)
        clr_vec = accept ? (NUM_VEC'(1) << wr_vec_q) : '0;
        pba_d   = (pba_q & ~clr_vec) | intr_req;
    end

    // State, pending bits and latched write fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pba_q     <= '0;
            rr_ptr_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_vec_q  <= '0;
        end else begin
            state_q   <= state_d;
            pba_q     <= pba_d;
            rr_ptr_q  <= rr_ptr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_vec_q  <= wr_vec_d;
        end
    end

    assign pba      = pba_q;
    assign wr_valid = (state_q == ISSUE);
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_vec   = wr_vec_q;
    assign sent     = accept;

endmodule

// File: tb/tb_msix_vec_engine.sv
// Scoreboard bench for msix_vec_engine: expected writes queued at stimulus time.
module tb_msix_vec_engine;
    import msix_pkg::*;

    localparam int NV = 8;
    localparam int AW = 64;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NV-1:0] intr_req = '0;
    logic          msix_en = 1'b0, func_mask = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [1:0]    cfg_field = '0;
    logic [31:0]   cfg_wdata = '0;
    logic [31:0]   cfg_rdata;
    logic [NV-1:0] pba;
    logic          wr_valid, wr_ready = 1'b1;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [IW-1:0] wr_vec;
    logic          sent;

    always #5 clk = ~clk;

    msix_vec_engine #(.NUM_VEC(NV), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .intr_req(intr_req), .msix_en(msix_en), .func_mask(func_mask),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_field(cfg_field), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .pba(pba), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_vec(wr_vec), .sent(sent)
    );

    typedef struct {
        logic [IW-1:0] vec;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;
    logic [AW-1:0] m_addr [NV];
    logic [31:0]   m_data [NV];

    // Scoreboard monitor: every accepted write must match the queue head
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            if (wr_valid && wr_ready) begin
                checks++;
                if (sent !== 1'b1) begin failures++; $display("FAIL sent_on_accept: got %b want 1", sent); end
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: got vec %0d addr %h, want none", wr_vec, wr_addr);
                end else begin
                    e = sb.pop_front();
                    if (wr_vec !== e.vec || wr_addr !== e.addr || wr_data !== e.data) begin
                        failures++;
                        $display("FAIL write_content: got vec %0d addr %h data %h, want vec %0d addr %h data %h",
                                 wr_vec, wr_addr, wr_data, e.vec, e.addr, e.data);
                    end
                end
            end else begin
                checks++;
                if (sent !== 1'b0) begin failures++; $display("FAIL sent_idle: got %b want 0", sent); end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input int idx, input logic [1:0] f, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_field = f; cfg_wdata = d;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic program_vec(input int idx, input logic [63:0] a, input logic [31:0] d, input logic msk);
        cfg_wr(idx, FLD_ADDR_LO, a[31:0]);
        cfg_wr(idx, FLD_ADDR_HI, a[63:32]);
        cfg_wr(idx, FLD_DATA, d);
        cfg_wr(idx, FLD_CTRL, {31'd0, msk});
        m_addr[idx] = {a[63:2], 2'b00};
        m_data[idx] = d;
    endtask

    task automatic pulse(input logic [NV-1:0] v);
        intr_req = v;
        cyc(1);
        intr_req = '0;
    endtask

    task automatic expect_wr(input int idx);
        sb.push_back('{vec: IW'(idx), addr: m_addr[idx], data: m_data[idx]});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin cyc(1); n++; end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d writes outstanding, want 0", name, sb.size());
            sb.delete();
        end
        cyc(2);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!wr_valid && n < 20) begin cyc(1); n++; end
        checks++;
        if (wr_valid !== 1'b1) begin failures++; $display("FAIL %s_valid_timeout: got %b want 1", name, wr_valid); end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_ready = 1'b1;
        cyc(2);
        checks++; if (pba !== 8'h00) begin failures++; $display("FAIL reset_pba: got %h want 00", pba); end
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", wr_valid); end
        checks++; if (wr_addr !== 64'd0 || wr_data !== 32'd0 || wr_vec !== 3'd0) begin
            failures++; $display("FAIL reset_wr_fields: got %h %h %0d want 0 0 0", wr_addr, wr_data, wr_vec); end
        checks++; if (sent !== 1'b0) begin failures++; $display("FAIL reset_sent: got %b want 0", sent); end
        cfg_idx = 3'd6; cfg_field = FLD_CTRL; #1;
        checks++; if (cfg_rdata !== 32'd1) begin failures++; $display("FAIL reset_mask: got %h want 1", cfg_rdata); end
        cfg_field = FLD_ADDR_LO; #1;
        checks++; if (cfg_rdata !== 32'd0) begin failures++; $display("FAIL reset_addr: got %h want 0", cfg_rdata); end
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_basic();
        msix_en = 1'b1;
        program_vec(2, 64'h0000_0001_FEE0_0004, 32'h42, 1'b0);
        program_vec(6, 64'h0000_0002_0000_1003, 32'h66, 1'b0);
        cfg_idx = 3'd2; cfg_field = FLD_ADDR_HI; #1;
        checks++; if (cfg_rdata !== 32'h1) begin failures++; $display("FAIL basic_rd_hi: got %h want 1", cfg_rdata); end
        cfg_field = FLD_DATA; #1;
        checks++; if (cfg_rdata !== 32'h42) begin failures++; $display("FAIL basic_rd_data: got %h want 42", cfg_rdata); end
        cfg_idx = 3'd6; cfg_field = FLD_ADDR_LO; #1;
        checks++; if (cfg_rdata !== 32'h1003) begin failures++; $display("FAIL basic_rd_lo_bits: got %h want 1003", cfg_rdata); end
        expect_wr(2);
        pulse(8'h04);
        drain("basic");
        checks++; if (pba !== 8'h00) begin failures++; $display("FAIL basic_pba: got %h want 00", pba); end
    endtask

    task automatic test_mask();
        logic saw = 1'b0;
        program_vec(5, 64'h0000_0001_FEE0_0050, 32'h55, 1'b1);
        pulse(8'h20);
        for (int i = 0; i < 20; i++) begin cyc(1); if (wr_valid) saw = 1'b1; end
        checks++; if (saw !== 1'b0) begin failures++; $display("FAIL mask_blocked: got valid %b want 0", saw); end
        checks++; if (pba !== 8'h20) begin failures++; $display("FAIL mask_pba_held: got %h want 20", pba); end
        expect_wr(5);
        cfg_wr(5, FLD_CTRL, 32'd0);
        drain("mask");
        checks++; if (pba !== 8'h00) begin failures++; $display("FAIL mask_pba_clear: got %h want 00", pba); end
    endtask

    task automatic test_round_robin();
        program_vec(0, 64'h0000_0001_FEE0_0000, 32'h10, 1'b0);
        program_vec(3, 64'h0000_0001_FEE0_0030, 32'h13, 1'b0);
        program_vec(7, 64'h0000_0001_FEE0_0070, 32'h17, 1'b0);
        expect_wr(7);                 // park ptr at 0 via wrap
        pulse(8'h80);
        drain("rr_park");
        expect_wr(0); expect_wr(3); expect_wr(7);
        pulse(8'h89);
        drain("rr_three");
        expect_wr(0); expect_wr(7);
        pulse(8'h81);
        drain("rr_wrap");
    endtask

    task automatic test_hold();
        logic [AW-1:0] a; logic [31:0] d; logic [IW-1:0] v; logic stable = 1'b1;
        wr_ready = 1'b0;
        expect_wr(3);
        pulse(8'h08);
        wait_valid("hold");
        a = wr_addr; d = wr_data; v = wr_vec;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) cfg_wr(3, FLD_DATA, 32'h99); else cyc(1);
            if (!wr_valid || wr_addr !== a || wr_data !== d || wr_vec !== v) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin failures++; $display("FAIL hold_stable: got %b want 1", stable); end
        checks++; if (wr_data !== 32'h13) begin failures++; $display("FAIL hold_old_data: got %h want 13", wr_data); end
        wr_ready = 1'b1;
        drain("hold");
        m_data[3] = 32'h99;
        cfg_idx = 3'd3; cfg_field = FLD_DATA; #1;
        checks++; if (cfg_rdata !== 32'h99) begin failures++; $display("FAIL hold_new_data: got %h want 99", cfg_rdata); end
    endtask

    task automatic test_same_cycle_write();
        program_vec(4, 64'h0000_0001_FEE0_0040, 32'h44, 1'b0);
        expect_wr(4);                 // grant sees the pre-write data
        intr_req = 8'h10;
        cyc(1);
        intr_req = '0;
        cfg_wr(4, FLD_DATA, 32'h4444);
        m_data[4] = 32'h4444;
        drain("same_cycle");
    endtask

    task automatic test_set_wins();
        program_vec(1, 64'h0000_0001_FEE0_0010, 32'h11, 1'b0);
        wr_ready = 1'b0;
        expect_wr(1); expect_wr(1);
        pulse(8'h02);
        wait_valid("setwin");
        wr_ready = 1'b1; intr_req = 8'h02;
        cyc(1);
        intr_req = '0;
        @(negedge clk);
        checks++; if (pba[1] !== 1'b1) begin failures++; $display("FAIL setwin_pba: got %b want 1", pba[1]); end
        drain("setwin");
        checks++; if (pba !== 8'h00) begin failures++; $display("FAIL setwin_pba_clear: got %h want 00", pba); end
    endtask

    task automatic test_func_mask();
        logic saw = 1'b0;
        func_mask = 1'b1;
        pulse(8'h54);
        for (int i = 0; i < 15; i++) begin cyc(1); if (wr_valid) saw = 1'b1; end
        checks++; if (saw !== 1'b0) begin failures++; $display("FAIL fmask_blocked: got valid %b want 0", saw); end
        checks++; if (pba !== 8'h54) begin failures++; $display("FAIL fmask_pba: got %h want 54", pba); end
        expect_wr(2); expect_wr(4); expect_wr(6);
        func_mask = 1'b0;
        drain("fmask");
        checks++; if (pba !== 8'h00) begin failures++; $display("FAIL fmask_pba_clear: got %h want 00", pba); end
    endtask

    task automatic test_reset_mid_issue();
        wr_ready = 1'b0;
        pulse(8'h04);
        wait_valid("rstmid");
        pulse(8'h10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b want 0", wr_valid); end
        checks++; if (pba !== 8'h00) begin failures++; $display("FAIL rstmid_pba: got %h want 00", pba); end
        cyc(2);
        rst = 1'b0; wr_ready = 1'b1;
        cyc(3);
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL rstmid_after: got %b want 0", wr_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_round_robin();
        test_hold();
        test_same_cycle_write();
        test_set_wins();
        test_func_mask();
        test_reset_mid_issue();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL final_scoreboard: got %0d left want 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
